ofmap_wr_buffer: RTL and testbench
==================================

Name: ofmap_wr_buffer

Overview:
- Memory-side receiver for the datapath's output-activation write interface (o_data_wr / o_data_wrh / o_data_wrh_l_n / o_data plus even/odd bank select and addresses).
- Accepts full-word and half-word result writes and merges complementary half-words aimed at the same bank/address into one full-word write.
- Queues the writes in a small FIFO and drains them to the even and odd activation SRAM banks over a req/gnt handshake.
- Sits between dp and the banked ofmap memory, replacing the bench-side memory model in the integrated NPU.

Parameters:
- N, 4, bits per lane (activation wordlength).
- W, 8, lanes per word; W is even.
- AW, 8, bank address width (CLOG2M+CLOG2W).
- DEPTH, 4, FIFO entries (power of 2, >=2).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_ev_odd_n  in  1  bank select, 1 = odd bank, 0 = even bank; leads i_wr by one cycle.
- i_even_addr  in  AW  even-bank address; leads i_wr by one cycle.
- i_odd_addr  in  AW  odd-bank address; leads i_wr by one cycle.
- i_wr  in  1  write strobe.
- i_wrh  in  1  half-word write when 1.
- i_wrh_l_n  in  1  with i_wrh: 1 = lower half (bits N*W/2-1:0), 0 = upper half.
- i_data  in  N*W  write data; lane 0 occupies the MSBs.
- i_flush  in  1  end-of-layer flush request, level, sampled.
- mem_req  out  1  write request to the bank selected by mem_odd_sel.
- mem_odd_sel  out  1  1 = odd bank, 0 = even bank.
- mem_addr  out  AW  write address.
- mem_wdata  out  N*W  write data.
- mem_lmask  out  W  lane write mask; bit W-1 = lane 0.
- mem_gnt  in  1  write accepted this cycle.
- o_busy  out  1  staging register or FIFO non-empty.
- o_ovf  out  1  sticky overflow flag.
- o_flush_done  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0, staging register invalid, FIFO empty, flush-pending flag cleared. Reset is asynchronous: mem_req drops immediately and all queued data is discarded.
- Target register:
  - {i_ev_odd_n, i_even_addr, i_odd_addr} is registered every cycle.
  - A write sampled at edge t uses the target sampled at edge t-1.
  - Address = odd_addr if bank is odd, else even_addr.
- Incoming entry = {bank, addr, data, mask}:
  - mask = all-ones if i_wrh=0.
  - upper half (lanes 0..W/2-1) if i_wrh=1 and i_wrh_l_n=0.
  - lower half otherwise.
- Staging register, one entry; at most one FIFO push per cycle. On i_wr:
  - Staging valid, same bank and addr, masks disjoint: merge (lanes taken from the incoming entry where its mask is set, else kept), mask |= incoming mask, no push.
  - Otherwise: push staging to the FIFO if valid, then load the incoming entry into staging.
- No i_wr and staging valid: push staging if its mask is all-ones, or if i_flush / flush-pending is set.
- Push while FIFO full and no pop in the same cycle: entry dropped, o_ovf <= 1 (sticky until reset).
- Push and pop in the same cycle when full: legal, no overflow.
- FIFO drain:
  - mem_req = FIFO not empty; mem_* outputs are driven from the head entry, combinationally from FIFO storage.
  - Pop on mem_req & mem_gnt.
  - Strict in-order drain; both banks share one port.
- Latency: full-word write sampled at edge t with FIFO empty and no following write → mem_req high from just after edge t+1. With mem_gnt=1 the entry is retired at edge t+2.
- Flush:
  - i_flush sets flush-pending.
  - While pending, a partial staging entry is pushed with its mask.
  - When staging is invalid and the FIFO is empty: o_flush_done pulses for one cycle, then pending clears.
  - i_flush with nothing buffered: o_flush_done pulses the next cycle.
  - i_wr during flush-pending is accepted normally and extends the flush.
- o_busy = staging valid | FIFO non-empty.
- Half writes to the same address and same half (masks overlap) are never merged. The first is pushed as a partial write.

Test Plan:
- Full write: target even addr 0x05, then i_wr data 0x12345678, mem_gnt=1 → one cycle with mem_req=1, mem_odd_sel=0, mem_addr=0x05, mem_wdata=0x12345678, mem_lmask=0xFF, 2 cycles after i_wr.
- Half merge: odd addr 0x10, upper half data 0xABCD0000, then lower half data 0x00001234 → single write: odd_sel=1, addr=0x10, wdata=0xABCD1234, lmask=0xFF.
- Partial flush: even addr 0x03, lower half 0x000000EF, then i_flush=1 → write lmask=0x0F, wdata=0x000000EF; o_flush_done pulses one cycle after the grant; o_busy=0 afterwards.
- Overflow: mem_gnt=0, six full writes to addrs 1..6, DEPTH=4 → o_ovf=1 on the sixth write. After releasing mem_gnt the writes drain in order with addrs 1,2,3,4,6 (5 dropped).
- Same-half collision: two upper-half writes to odd addr 0x20, data 0x11110000 then 0x22220000 → two writes, lmask=0xF0, in order 0x1111..., then 0x2222....
- Reset mid-drain: two entries queued with mem_gnt=0, assert rst asynchronously → mem_req=0, o_busy=0, o_ovf=0 with no clock edge; no mem_req after release until new writes arrive.

Source files
------------

// File: rtl/ofmap_wr_buffer.sv
// Output-activation write receiver: merges complementary half-word writes in a
// one-entry staging register and drains them in order through a FIFO to the even/odd banks.
module ofmap_wr_buffer #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            i_ev_odd_n,
    input  logic [AW-1:0]   i_even_addr,
    input  logic [AW-1:0]   i_odd_addr,
    input  logic            i_wr,
    input  logic            i_wrh,
    input  logic            i_wrh_l_n,
    input  logic [N*W-1:0]  i_data,
    input  logic            i_flush,
    output logic            mem_req,
    output logic            mem_odd_sel,
    output logic [AW-1:0]   mem_addr,
    output logic [N*W-1:0]  mem_wdata,
    output logic [W-1:0]    mem_lmask,
    input  logic            mem_gnt,
    output logic            o_busy,
    output logic            o_ovf,
    output logic            o_flush_done
);
    localparam int DW = N * W;
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic          odd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [W-1:0]  mask;
    } entry_t;

    logic          tgt_odd_q;
    logic [AW-1:0] tgt_even_addr_q;
    logic [AW-1:0] tgt_odd_addr_q;

    entry_t        in_e;
    entry_t        merged;
    entry_t        stg;
    entry_t        stg_n;
    logic          stg_v;
    logic          stg_v_n;
    logic [DW-1:0] lane_bits;
    logic          can_merge;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          flush_any;
    logic          flush_pend;
    logic          done_cond;

    entry_t        fifo_mem [DEPTH];
    entry_t        head;
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    // Target leads the strobe by one cycle, so the entry is built from the registered copy.
    always_comb begin
        in_e      = '0;
        in_e.odd  = tgt_odd_q;
        in_e.addr = tgt_odd_q ? tgt_odd_addr_q : tgt_even_addr_q;
        in_e.data = i_data;
        if (!i_wrh)
            in_e.mask = '1;
        else if (!i_wrh_l_n)
            in_e.mask = {{(W/2){1'b1}}, {(W/2){1'b0}}};
        else
            in_e.mask = {{(W/2){1'b0}}, {(W/2){1'b1}}};
    end

    always_comb begin
        lane_bits = '0;
        for (int j = 0; j < W; j++)
            lane_bits[j*N +: N] = {N{in_e.mask[j]}};
    end

    always_comb begin
        merged      = stg;
        merged.data = (stg.data & ~lane_bits) | (i_data & lane_bits);
        merged.mask = stg.mask | in_e.mask;
    end

    assign can_merge = stg_v && (stg.odd == in_e.odd) && (stg.addr == in_e.addr)
                       && ((stg.mask & in_e.mask) == '0);
    assign flush_any = i_flush | flush_pend;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop       = !empty && mem_gnt;
    assign done_cond = flush_any && !stg_v && empty && !i_wr;

    always_comb begin
        push    = 1'b0;
        stg_n   = stg;
        stg_v_n = stg_v;
        if (i_wr) begin
            if (can_merge) begin
                stg_n = merged;
            end else begin
                push    = stg_v;
                stg_n   = in_e;
                stg_v_n = 1'b1;
            end
        end else if (stg_v && ((&stg.mask) || flush_any)) begin
            push    = 1'b1;
            stg_v_n = 1'b0;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            tgt_odd_q       <= 1'b0;
            tgt_even_addr_q <= '0;
            tgt_odd_addr_q  <= '0;
            stg             <= '0;
            stg_v           <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_ovf           <= 1'b0;
            flush_pend      <= 1'b0;
            o_flush_done    <= 1'b0;
        end else begin
            tgt_odd_q       <= i_ev_odd_n;
            tgt_even_addr_q <= i_even_addr;
            tgt_odd_addr_q  <= i_odd_addr;
            stg             <= stg_n;
            stg_v           <= stg_v_n;
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                o_ovf <= 1'b1;
            flush_pend   <= flush_any && !done_cond;
            o_flush_done <= done_cond;
        end
    end

    // Storage needs no reset: the pointers alone define what is queued.
    always_ff @(posedge ck) begin
        if (push && (!full || pop))
            fifo_mem[wr_ptr[PW-1:0]] <= stg;
    end

    assign head        = fifo_mem[rd_ptr[PW-1:0]];
    assign mem_req     = !empty;
    assign mem_odd_sel = !empty && head.odd;
    assign mem_addr    = empty ? '0 : head.addr;
    assign mem_wdata   = empty ? '0 : head.data;
    assign mem_lmask   = empty ? '0 : head.mask;
    assign o_busy      = stg_v || !empty;

endmodule

// File: tb/tb_ofmap_wr_buffer.sv
// Directed bench for ofmap_wr_buffer: full write, half merge, partial flush,
// same-half collision, overflow and asynchronous reset.
module tb_ofmap_wr_buffer;
    logic        ck = 1'b0;
    logic        rst;
    logic        i_ev_odd_n;
    logic [7:0]  i_even_addr;
    logic [7:0]  i_odd_addr;
    logic        i_wr;
    logic        i_wrh;
    logic        i_wrh_l_n;
    logic [31:0] i_data;
    logic        i_flush;
    logic        mem_req;
    logic        mem_odd_sel;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_lmask;
    logic        mem_gnt;
    logic        o_busy;
    logic        o_ovf;
    logic        o_flush_done;

    int checks   = 0;
    int failures = 0;

    logic [48:0] wq[$];

    ofmap_wr_buffer #(.N(4), .W(8), .AW(8), .DEPTH(4)) dut (
        .ck(ck), .rst(rst),
        .i_ev_odd_n(i_ev_odd_n), .i_even_addr(i_even_addr), .i_odd_addr(i_odd_addr),
        .i_wr(i_wr), .i_wrh(i_wrh), .i_wrh_l_n(i_wrh_l_n), .i_data(i_data),
        .i_flush(i_flush),
        .mem_req(mem_req), .mem_odd_sel(mem_odd_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_lmask(mem_lmask), .mem_gnt(mem_gnt),
        .o_busy(o_busy), .o_ovf(o_ovf), .o_flush_done(o_flush_done)
    );

    always #5 ck = ~ck;

    // Inputs change 1 time unit after posedge, so at negedge req/gnt show the coming handshake.
    always @(negedge ck)
        if (!rst && mem_req && mem_gnt)
            wq.push_back({mem_odd_sel, mem_addr, mem_wdata, mem_lmask});

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tgt(input logic odd, input logic [7:0] addr);
        i_ev_odd_n  = odd;
        i_even_addr = odd ? ~addr : addr;
        i_odd_addr  = odd ? addr : ~addr;
    endtask

    task automatic wr_on(input logic [31:0] d, input logic wrh, input logic lo);
        i_wr      = 1'b1;
        i_data    = d;
        i_wrh     = wrh;
        i_wrh_l_n = lo;
    endtask

    task automatic wr_off();
        i_wr   = 1'b0;
        i_data = '0;
        i_wrh  = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; i_wr = 0; i_wrh = 0; i_wrh_l_n = 0; i_data = '0;
        i_flush = 0; mem_gnt = 0; tgt(1'b0, 8'h00);
        cyc(); cyc();
        chk("rst_req", mem_req, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ovf", o_ovf, 1'b0);
        chk("rst_done", o_flush_done, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        rst = 1'b0;
        cyc();

        // Full write: mem_req one cycle after the sampling edge, retired on the next.
        mem_gnt = 1'b1; wq.delete();
        tgt(1'b0, 8'h05); cyc();
        wr_on(32'h12345678, 1'b0, 1'b0); cyc();
        wr_off();
        chk("full_staged_req", mem_req, 1'b0);
        chk("full_staged_busy", o_busy, 1'b1);
        cyc();
        chk("full_req", mem_req, 1'b1);
        chk("full_sel", mem_odd_sel, 1'b0);
        chk("full_addr", mem_addr, 8'h05);
        chk("full_wdata", mem_wdata, 32'h12345678);
        chk("full_lmask", mem_lmask, 8'hFF);
        cyc();
        chk("full_retired_req", mem_req, 1'b0);
        chk("full_retired_busy", o_busy, 1'b0);
        chk("full_count", wq.size(), 1);

        // Complementary halves to the same odd address merge into one full write.
        wq.delete();
        tgt(1'b1, 8'h10); cyc();
        wr_on(32'hABCD0000, 1'b1, 1'b0); cyc();
        wr_on(32'h00001234, 1'b1, 1'b1); cyc();
        wr_off();
        chk("merge_no_req", mem_req, 1'b0);
        cyc(); cyc(); cyc();
        chk("merge_count", wq.size(), 1);
        if (wq.size() >= 1) chk("merge_entry", wq[0], {1'b1, 8'h10, 32'hABCD1234, 8'hFF});

        // A partial entry waits in staging until a flush pushes it with its mask.
        wq.delete();
        tgt(1'b0, 8'h03); cyc();
        wr_on(32'h000000EF, 1'b1, 1'b1); cyc();
        wr_off(); cyc(); cyc();
        chk("partial_held_req", mem_req, 1'b0);
        chk("partial_held_busy", o_busy, 1'b1);
        i_flush = 1'b1; cyc();
        i_flush = 1'b0;
        chk("flush_req", mem_req, 1'b1);
        chk("flush_lmask", mem_lmask, 8'h0F);
        chk("flush_wdata", mem_wdata, 32'h000000EF);
        chk("flush_addr", mem_addr, 8'h03);
        chk("flush_done_early", o_flush_done, 1'b0);
        cyc();
        chk("flush_done_at_grant", o_flush_done, 1'b0);
        cyc();
        chk("flush_done_pulse", o_flush_done, 1'b1);
        chk("flush_busy", o_busy, 1'b0);
        cyc();
        chk("flush_done_width", o_flush_done, 1'b0);
        chk("flush_count", wq.size(), 1);

        // Flush with nothing buffered completes on the next cycle.
        i_flush = 1'b1; cyc();
        i_flush = 1'b0;
        chk("idle_flush_done", o_flush_done, 1'b1);
        cyc();
        chk("idle_flush_width", o_flush_done, 1'b0);

        // Overlapping halves never merge: two partial writes in order.
        wq.delete();
        tgt(1'b1, 8'h20); cyc();
        wr_on(32'h11110000, 1'b1, 1'b0); cyc();
        wr_on(32'h22220000, 1'b1, 1'b0); cyc();
        wr_off();
        chk("coll_first_req", mem_req, 1'b1);
        chk("coll_first_lmask", mem_lmask, 8'hF0);
        i_flush = 1'b1; cyc();
        i_flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_flush_done) seen = 1;
            if (seen == 0) cyc();
        end
        chk("coll_flush_done_seen", seen, 1);
        chk("coll_count", wq.size(), 2);
        if (wq.size() >= 2) begin
            chk("coll_entry0", wq[0], {1'b1, 8'h20, 32'h11110000, 8'hF0});
            chk("coll_entry1", wq[1], {1'b1, 8'h20, 32'h22220000, 8'hF0});
        end

        // Overflow: six back-to-back full writes with no grant, the fifth is dropped.
        wq.delete();
        mem_gnt = 1'b0;
        cyc();
        tgt(1'b0, 8'h01); cyc();
        for (int k = 1; k <= 6; k++) begin
            logic [7:0] d8;
            d8 = 8'(k);
            wr_on({4{d8}}, 1'b0, 1'b0);
            tgt(1'b0, 8'(k + 1));
            cyc();
            chk($sformatf("ovf_after_write%0d", k), o_ovf, (k == 6) ? 1'b1 : 1'b0);
        end
        wr_off();
        mem_gnt = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        chk("ovf_sticky", o_ovf, 1'b1);
        chk("ovf_busy", o_busy, 1'b0);
        chk("ovf_count", wq.size(), 5);
        if (wq.size() >= 5) begin
            chk("ovf_e0", wq[0], {1'b0, 8'h01, 32'h01010101, 8'hFF});
            chk("ovf_e1", wq[1], {1'b0, 8'h02, 32'h02020202, 8'hFF});
            chk("ovf_e2", wq[2], {1'b0, 8'h03, 32'h03030303, 8'hFF});
            chk("ovf_e3", wq[3], {1'b0, 8'h04, 32'h04040404, 8'hFF});
            chk("ovf_e4", wq[4], {1'b0, 8'h06, 32'h06060606, 8'hFF});
        end

        // Asynchronous reset while entries are queued.
        wq.delete();
        mem_gnt = 1'b0;
        tgt(1'b0, 8'h30); cyc();
        wr_on(32'hCAFEF00D, 1'b0, 1'b0); tgt(1'b0, 8'h31); cyc();
        wr_on(32'h0BADBEEF, 1'b0, 1'b0); cyc();
        wr_off(); cyc();
        chk("prerst_req", mem_req, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_busy", o_busy, 1'b0);
        chk("async_rst_ovf", o_ovf, 1'b0);
        cyc();
        rst = 1'b0;
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        chk("postrst_req", mem_req, 1'b0);
        chk("postrst_count", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
